// File: rtl/srate_crush.sv
// Sample-rate crusher: holds three audio channels for P sample ticks, with P set by a CV input.
// Optional period jitter compiled in with SRATE_CRUSH_JITTER_EN.

module srate_crush #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sample_clk,
  input  logic [W-1:0] sample_in0,
  input  logic [W-1:0] sample_in1,
  input  logic [W-1:0] sample_in2,
  input  logic [W-1:0] sample_in3,
  output logic [W-1:0] sample_out0,
  output logic [W-1:0] sample_out1,
  output logic [W-1:0] sample_out2,
  output logic [W-1:0] sample_out3,
  output logic         capture
);

  // state | meaning
  // IDLE  | out of reset; the first tick always captures
  // HOLD  | holding captured samples; cnt counts ticks left before the next capture
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        sclk_q;
  logic        tick;
  logic [3:0]  cnt_q, cnt_d;
  logic        take;
  logic [W-1:0] cv_shr;
  logic [4:0]  period;
  logic [3:0]  reload;

  assign sample_out0 = sample_in0;
  assign tick        = sample_clk & ~sclk_q;

  // Hold period from CV: roughly 1 step per 256 mV, negative CV means no crushing.
  assign cv_shr = sample_in0 >> 10;

  always_comb begin
    period = 5'd1;
    if (sample_in0[W-1]) begin
      period = 5'd1;
    end else if (cv_shr >= W'(15)) begin
      period = 5'd16;
    end else begin
      period = {1'b0, cv_shr[3:0]} + 5'd1;
    end
  end

`ifdef SRATE_CRUSH_JITTER_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;
  logic [4:0]  reload_sum;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else if (tick) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  // Stretch the hold by 0..3 ticks, saturating so cnt never exceeds 15.
  assign reload_sum = (period - 5'd1) + {3'b000, lfsr_q[1:0]};
  assign reload     = (reload_sum > 5'd15) ? 4'd15 : reload_sum[3:0];
`else
  logic [4:0] period_m1;

  assign period_m1 = period - 5'd1;
  assign reload    = period_m1[3:0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          take    = 1'b1;
          cnt_d   = reload;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (tick) begin
          if (cnt_q == 4'd0) begin
            take  = 1'b1;
            cnt_d = reload;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sclk_q  <= 1'b0;
      capture <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sample_clk;
      capture <= take;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out1 <= '0;
      sample_out2 <= '0;
      sample_out3 <= '0;
    end else if (take) begin
      sample_out1 <= sample_in1;
      sample_out2 <= sample_in2;
      sample_out3 <= sample_in3;
    end
  end

endmodule

// File: tb/tb_srate_crush.sv
// Directed bench for srate_crush: pass-through, fixed holds, CV change mid-hold,
// long strobe, reset mid-hold and hold-length statistics (with or without jitter).

module tb_srate_crush;

  logic        clk;
  logic        rst_n;
  logic        sample_clk;
  logic [15:0] sample_in0, sample_in1, sample_in2, sample_in3;
  logic [15:0] sample_out0, sample_out1, sample_out2, sample_out3;
  logic        capture;

  int tests = 0;
  int fails = 0;

  logic        cap0, cap1;
  logic [15:0] o1, o2, o3;

  srate_crush #(.W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_clk  (sample_clk),
    .sample_in0  (sample_in0),
    .sample_in1  (sample_in1),
    .sample_in2  (sample_in2),
    .sample_in3  (sample_in3),
    .sample_out0 (sample_out0),
    .sample_out1 (sample_out1),
    .sample_out2 (sample_out2),
    .sample_out3 (sample_out3),
    .capture     (capture)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sample_clk pulse (high two clk cycles). Outputs sampled 1 ns after the
  // edge that registers the tick, and capture again one cycle later.
  task automatic tick(input int gap);
    @(negedge clk);
    sample_clk = 1'b1;
    @(posedge clk);
    #1;
    cap0 = capture;
    o1   = sample_out1;
    o2   = sample_out2;
    o3   = sample_out3;
    @(posedge clk);
    #1;
    cap1 = capture;
    @(negedge clk);
    sample_clk = 1'b0;
    repeat (gap - 3) @(negedge clk);
  endtask

  initial begin
    int last;
    int ncap;
    logic [15:0] exp1;

    rst_n      = 1'b0;
    sample_clk = 1'b0;
    sample_in0 = 16'd0;
    sample_in1 = 16'h0000;
    sample_in2 = 16'h0000;
    sample_in3 = 16'h0000;
    #1;
    check("rst_out1", 32'(sample_out1), 32'h0);
    check("rst_out2", 32'(sample_out2), 32'h0);
    check("rst_out3", 32'(sample_out3), 32'h0);
    check("rst_capture", 32'(capture), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // CV=0: every tick captures, bit-exact on all three channels
    for (int i = 0; i < 6; i++) begin
      sample_in1 = 16'h0100 + 16'(i);
      sample_in2 = 16'h8000 + 16'(i * 3);
      sample_in3 = 16'hFFFF - 16'(i);
      tick(8);
`ifndef SRATE_CRUSH_JITTER_EN
      check($sformatf("p1_out1_%0d", i), 32'(o1), 32'(16'h0100 + 16'(i)));
      check($sformatf("p1_out2_%0d", i), 32'(o2), 32'(16'h8000 + 16'(i * 3)));
      check($sformatf("p1_out3_%0d", i), 32'(o3), 32'(16'hFFFF - 16'(i)));
      check($sformatf("p1_cap_%0d", i), 32'(cap0), 32'h1);
`endif
      check($sformatf("p1_cap_pulse_%0d", i), 32'(cap1), 32'h0);
    end

    // CV=4000 -> P=4: holds 1, 5, 9
    sample_in0 = 16'd4000;
    check("mirror_out0", 32'(sample_out0), 32'd4000);
    for (int i = 1; i <= 12; i++) begin
      sample_in1 = 16'(i);
      tick(8);
`ifndef SRATE_CRUSH_JITTER_EN
      exp1 = 16'(1 + 4 * ((i - 1) / 4));
      check($sformatf("p4_out1_%0d", i), 32'(o1), 32'(exp1));
      check($sformatf("p4_cap_%0d", i), 32'(cap0), 32'(((i - 1) % 4) == 0));
`endif
    end

    // CV=20000 -> P=16, CV dropped to 0 on the 4th tick; full hold must complete
    sample_in0 = 16'd20000;
    for (int i = 1; i <= 18; i++) begin
      if (i == 4) sample_in0 = 16'd0;
      sample_in1 = 16'(1000 + i);
      tick(8);
`ifndef SRATE_CRUSH_JITTER_EN
      exp1 = (i <= 16) ? 16'd1001 : 16'(1000 + i);
      check($sformatf("p16_out1_%0d", i), 32'(o1), 32'(exp1));
      check($sformatf("p16_cap_%0d", i), 32'(cap0), 32'((i == 1) || (i >= 17)));
`endif
    end

    // sample_clk held high 50 clk -> one tick, one capture
    sample_in0 = 16'd0;
    sample_in1 = 16'h5555;
    ncap = 0;
    @(negedge clk);
    sample_clk = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (capture) ncap++;
      sample_in1 = 16'h6666;
    end
    @(negedge clk);
    sample_clk = 1'b0;
    repeat (4) @(negedge clk);
`ifndef SRATE_CRUSH_JITTER_EN
    check("long_high_captures", 32'(ncap), 32'd1);
    check("long_high_out1", 32'(sample_out1), 32'h5555);
`else
    check("long_high_captures_max1", 32'(ncap <= 1), 32'd1);
`endif

    // Reset mid-hold: forced to zero, next tick after release captures
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    sample_in0 = 16'd4000;
    sample_in1 = 16'h1234;
    tick(8);
    check("rh_first_out1", 32'(o1), 32'h1234);
    check("rh_first_cap", 32'(cap0), 32'h1);
    sample_in1 = 16'h2222;
    tick(8);
    check("rh_hold_out1", 32'(o1), 32'h1234);
    check("rh_hold_cap", 32'(cap0), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rh_async_out1", 32'(sample_out1), 32'h0);
    check("rh_async_cap", 32'(capture), 32'h0);
    sample_in0 = 16'h8123;
    #1;
    check("rh_mirror_in_reset", 32'(sample_out0), 32'h8123);
    sample_in0 = 16'd4000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    sample_in1 = 16'h3333;
    tick(8);
    check("rh_post_out1", 32'(o1), 32'h3333);
    check("rh_post_cap", 32'(cap0), 32'h1);

    // 1000 ticks at CV=4000: hold lengths 4 (4..7 with jitter)
    last = -1;
    for (int t = 0; t < 1000; t++) begin
      sample_in1 = 16'(t);
      tick(4);
      if (cap0) begin
        if (last >= 0) begin
`ifdef SRATE_CRUSH_JITTER_EN
          check($sformatf("jit_hold_%0d", t), 32'((t - last) >= 4 && (t - last) <= 7), 32'd1);
`else
          check($sformatf("det_hold_%0d", t), 32'(t - last), 32'd4);
`endif
        end
        check($sformatf("hold_val_%0d", t), 32'(o1), 32'(16'(t)));
        last = t;
      end
    end
    check("hold_seen", 32'(last >= 900), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/srate_crush.md
SRATE_CRUSH -- requirements
Module: srate_crush

Interface
REQ-001 SHALL provide parameter W, default 16, giving the sample width in bits (signed two's complement).
REQ-002 SHALL have port clk  input  1  single system clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert and active-low.
REQ-004 SHALL have port sample_clk  input  1  sample-rate strobe level, sampled in the clk domain.
REQ-005 SHALL have port sample_in0  input  W  rate-control CV: 4 counts/mV, 0-5V nominal.
REQ-006 SHALL have ports sample_in1..sample_in3  input  W each  audio inputs.
REQ-007 SHALL have port sample_out0  output  W  combinational mirror of sample_in0.
REQ-008 SHALL have ports sample_out1..sample_out3  output  W each  held (rate-reduced) audio, registered.
REQ-009 SHALL have port capture  output  1  one-clk pulse, high in the cycle after each new capture is taken.

Function
REQ-010 SHALL register sample_clk once (sclk_q) and define tick = sample_clk AND NOT sclk_q, so tick is exactly one clk cycle per rising edge.
REQ-011 SHALL keep sample_clk held high for many cycles to a single tick.
REQ-012 SHALL compute hold period P (5 bits, range 1..16): P=1 if sample_in0 < 0, else P = min(16, (sample_in0 >> 10) + 1).
REQ-013 SHALL implement a two-state FSM: IDLE (after reset) and HOLD.
REQ-014 SHALL, in IDLE on tick: capture sample_in1..3 into the held registers, load cnt <= P-1 and go to HOLD.
REQ-015 SHALL, in HOLD on tick with cnt==0: capture sample_in1..3 and reload cnt <= P-1, with P evaluated in that cycle.
REQ-016 SHALL, in HOLD on tick with cnt!=0: decrement cnt and leave the held values unchanged.
REQ-017 SHALL leave state, cnt and the held registers unchanged in cycles without a tick.
REQ-018 SHALL ignore CV changes during a hold; a new P takes effect only at the next reload.
REQ-019 SHALL make the captured value visible on sample_out1..3 in the clk cycle after the tick, giving 1-clk latency; capture asserts in that same cycle.
REQ-020 SHALL make P=1 capture on every tick, which is a pass-through at sample rate.
REQ-021 SHALL make P=16 capture on every 16th tick.
REQ-022 SHALL keep cnt 4 bits wide; the reload value never exceeds 15 and cnt never wraps below 0.
REQ-023 SHALL NOT modify sample values: no arithmetic on audio, bit-exact copy.

Reset
REQ-024 SHALL, while rst_n is low, immediately force sample_out1..3 = 0, capture = 0, cnt = 0, sclk_q = 0 and state = IDLE.
REQ-025 SHALL, on reset asserted mid-hold, abandon the current hold; the first tick after release captures.
REQ-026 SHALL keep sample_out0 following sample_in0 during reset.

Configuration
REQ-027 SHALL use macro SRATE_CRUSH_JITTER_EN to compile period jitter in or out.
REQ-028 SHALL, with SRATE_CRUSH_JITTER_EN defined, include a 16-bit Fibonacci LFSR:
- taps 16,14,13,11; reset seed 16'hACE1
- advances once per tick
- reload value = min(15, P-1 + lfsr[1:0])
REQ-029 SHALL, without SRATE_CRUSH_JITTER_EN, contain no LFSR; reload is exactly P-1 and periods are deterministic.

Verification
REQ-030 SHALL cover CV=0, ticks every 8 clk, ramp on in1 -> out1 follows in1 each tick, 1-clk latency, capture every tick.
REQ-031 SHALL cover CV=4*1000=4000 (P=4), in1 incrementing per tick -> out1 changes every 4th tick, holding 1, 5, 9...
REQ-032 SHALL cover CV=20000 (P=16), then CV to 0 mid-hold -> the 16-tick hold completes before period-1 behaviour resumes.
REQ-033 SHALL cover sample_clk held high for 50 clk -> exactly one tick and at most one capture.
REQ-034 SHALL cover rst_n pulsed low mid-hold with out1=0x1234 -> out1=0 asynchronously; the next tick captures the current in1.
REQ-035 SHALL cover, with SRATE_CRUSH_JITTER_EN and CV=4000, 1000 ticks -> every hold length within 4..7 ticks and reload never >15; with the macro undefined -> all holds exactly 4.
